// File: rtl/id_ex_stage_pkg.sv
// Shared control-bundle layouts, memory/writeback encodings and BUBBLE constants
// for the decode->execute boundary of the reduced MIPS core.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_rdwr_e;

  typedef enum logic {
    WRB_READ  = 1'b0,
    WRB_WRITE = 1'b1
  } wrb_we_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_dst;
  } exe_ctrl_t;

  typedef struct packed {
    mem_rdwr_e  rdwr;
    logic [1:0] size;
    logic       sign_ext;
  } mem_ctrl_t;

  typedef struct packed {
    wrb_we_e wr_en;
    logic    mem_to_reg;
  } wrb_ctrl_t;

  // A BUBBLE must neither touch memory nor write the register file.
  localparam exe_ctrl_t BUBBLE_EXE_CTRL = '{alu_op: ALU_ADD, alu_src: 1'b0, reg_dst: 1'b0};
  localparam mem_ctrl_t BUBBLE_MEM_CTRL = '{rdwr: MEM_NONE, size: 2'b00, sign_ext: 1'b0};
  localparam wrb_ctrl_t BUBBLE_WRB_CTRL = '{wr_en: WRB_READ, mem_to_reg: 1'b0};

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detect: a load in EX whose destination rt is read by the
// instruction in ID. Purely combinational; r0 never creates a hazard.
import id_ex_stage_pkg::*;

module load_use_detector #(
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_enable,
  input  mem_rdwr_e              i_ex_rdwr,
  input  logic [NB_REG_ADDR-1:0] i_ex_rt_addr,
  input  logic [NB_REG_ADDR-1:0] i_id_rs_addr,
  input  logic [NB_REG_ADDR-1:0] i_id_rt_addr,
  output logic                   o_haz
);

  logic ex_is_load;
  logic addr_match;

  assign ex_is_load = (i_ex_rdwr == MEM_READ) && (i_ex_rt_addr != '0);
  assign addr_match = (i_ex_rt_addr == i_id_rs_addr) || (i_ex_rt_addr == i_id_rt_addr);
  assign o_haz      = i_enable && ex_is_load && addr_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and debug freeze; 1-cycle latency.
// Optional saturating load-use bubble counter when ID_EX_STALL_CNT_EN is defined.
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  exe_ctrl_t              i_exe_ctrl,
  input  mem_ctrl_t              i_mem_ctrl,
  input  wrb_ctrl_t              i_wrb_ctrl,
  input  logic [NB_DATA-1:0]     i_rs_data,
  input  logic [NB_DATA-1:0]     i_rt_data,
  input  logic [NB_DATA-1:0]     i_imm_ext,
  input  logic [NB_DATA-1:0]     i_pc_next,
  input  logic [NB_REG_ADDR-1:0] i_rs_addr,
  input  logic [NB_REG_ADDR-1:0] i_rt_addr,
  input  logic [NB_REG_ADDR-1:0] i_rd_addr,
  output exe_ctrl_t              o_exe_ctrl,
  output mem_ctrl_t              o_mem_ctrl,
  output wrb_ctrl_t              o_wrb_ctrl,
  output logic [NB_DATA-1:0]     o_rs_data,
  output logic [NB_DATA-1:0]     o_rt_data,
  output logic [NB_DATA-1:0]     o_imm_ext,
  output logic [NB_DATA-1:0]     o_pc_next,
  output logic [NB_REG_ADDR-1:0] o_rs_addr,
  output logic [NB_REG_ADDR-1:0] o_rt_addr,
  output logic [NB_REG_ADDR-1:0] o_rd_addr,
  output logic                   o_stall,
  output logic [NB_CNT-1:0]      o_stall_count
);

  logic haz;

  load_use_detector #(.NB_REG_ADDR(NB_REG_ADDR)) u_load_use_detector (
    .i_enable     (i_enable),
    .i_ex_rdwr    (o_mem_ctrl.rdwr),
    .i_ex_rt_addr (o_rt_addr),
    .i_id_rs_addr (i_rs_addr),
    .i_id_rt_addr (i_rt_addr),
    .o_haz        (haz)
  );

  // A flushed ID instruction is dead, so there is nothing worth holding.
  assign o_stall = haz & ~i_flush;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_exe_ctrl <= BUBBLE_EXE_CTRL;
      o_mem_ctrl <= BUBBLE_MEM_CTRL;
      o_wrb_ctrl <= BUBBLE_WRB_CTRL;
      o_rs_data  <= '0;
      o_rt_data  <= '0;
      o_imm_ext  <= '0;
      o_pc_next  <= '0;
      o_rs_addr  <= '0;
      o_rt_addr  <= '0;
      o_rd_addr  <= '0;
    end else if (i_enable) begin
      // Data and addresses always follow ID; only control decides whether EX does anything.
      o_rs_data <= i_rs_data;
      o_rt_data <= i_rt_data;
      o_imm_ext <= i_imm_ext;
      o_pc_next <= i_pc_next;
      o_rs_addr <= i_rs_addr;
      o_rt_addr <= i_rt_addr;
      o_rd_addr <= i_rd_addr;
      if (i_flush || haz) begin
        o_exe_ctrl <= BUBBLE_EXE_CTRL;
        o_mem_ctrl <= BUBBLE_MEM_CTRL;
        o_wrb_ctrl <= BUBBLE_WRB_CTRL;
      end else begin
        o_exe_ctrl <= i_exe_ctrl;
        o_mem_ctrl <= i_mem_ctrl;
        o_wrb_ctrl <= i_wrb_ctrl;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [NB_CNT-1:0] stall_cnt;

  // o_stall already implies i_enable and no flush, i.e. a hazard BUBBLE is being written.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cnt <= '0;
    end else if (o_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + NB_CNT'(1);
    end
  end

  assign o_stall_count = stall_cnt;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: each row is one clock edge; the expected
// EX-side contents are queued when the row is driven and checked after the edge.
import id_ex_stage_pkg::*;

module tb_id_ex_stage;

  typedef enum {K_LOAD, K_BUBBLE, K_HOLD, K_RESET} kind_e;

  typedef struct packed {
    exe_ctrl_t   exe;
    mem_ctrl_t   mem;
    wrb_ctrl_t   wrb;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    logic    rst;
    logic    en;
    logic    fl;
    bundle_t in;
    logic    chk_stall;
    logic    exp_stall;
    kind_e   kind;
    int      exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, fl;
  bundle_t     in_b;
  exe_ctrl_t   o_exe;
  mem_ctrl_t   o_mem;
  wrb_ctrl_t   o_wrb;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc, o_cnt;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic        o_stall;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];
  out_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_CNT(32)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_flush       (fl),
    .i_exe_ctrl    (in_b.exe),
    .i_mem_ctrl    (in_b.mem),
    .i_wrb_ctrl    (in_b.wrb),
    .i_rs_data     (in_b.rs_data),
    .i_rt_data     (in_b.rt_data),
    .i_imm_ext     (in_b.imm),
    .i_pc_next     (in_b.pc),
    .i_rs_addr     (in_b.rs_addr),
    .i_rt_addr     (in_b.rt_addr),
    .i_rd_addr     (in_b.rd_addr),
    .o_exe_ctrl    (o_exe),
    .o_mem_ctrl    (o_mem),
    .o_wrb_ctrl    (o_wrb),
    .o_rs_data     (o_rs_data),
    .o_rt_data     (o_rt_data),
    .o_imm_ext     (o_imm),
    .o_pc_next     (o_pc),
    .o_rs_addr     (o_rs_addr),
    .o_rt_addr     (o_rt_addr),
    .o_rd_addr     (o_rd_addr),
    .o_stall       (o_stall),
    .o_stall_count (o_cnt)
  );

  function automatic bundle_t data_of(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, int tag);
    bundle_t b;
    b         = '0;
    b.rs_addr = rs;
    b.rt_addr = rt;
    b.rd_addr = rd;
    b.rs_data = 32'hA000_0000 + 32'(tag) * 32'd256 + 32'(rs);
    b.rt_data = 32'hB000_0000 + 32'(tag) * 32'd256 + 32'(rt);
    b.imm     = {16'h0, rd, 11'(tag)};
    b.pc      = 32'h0040_0000 + 32'(tag) * 32'd4;
    return b;
  endfunction

  function automatic bundle_t r_op(alu_op_e op, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, int tag);
    bundle_t b;
    b                = data_of(rd, rs, rt, tag);
    b.exe.alu_op     = op;
    b.exe.reg_dst    = 1'b1;
    b.wrb.wr_en      = WRB_WRITE;
    return b;
  endfunction

  function automatic bundle_t lw(logic [4:0] rt, logic [4:0] rs, int tag);
    bundle_t b;
    b                = data_of(5'd0, rs, rt, tag);
    b.exe.alu_op     = ALU_ADD;
    b.exe.alu_src    = 1'b1;
    b.mem.rdwr       = MEM_READ;
    b.mem.size       = 2'b11;
    b.mem.sign_ext   = 1'b1;
    b.wrb.wr_en      = WRB_WRITE;
    b.wrb.mem_to_reg = 1'b1;
    return b;
  endfunction

  task automatic add(logic r, logic e, logic f, bundle_t b, logic chk, logic stl, kind_e k, int cnt);
    vec_t v;
    v.rst = r; v.en = e; v.fl = f; v.in = b;
    v.chk_stall = chk; v.exp_stall = stl; v.kind = k; v.exp_cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t    prev, e, got;
    vec_t    v;
    int      t;

    //   rst en fl  instruction                  chk stall kind       cnt
    t = 0;
    add(1, 1, 0, r_op(ALU_ADD, 3, 1, 2, t++),   0, 0, K_RESET,  0);
    add(1, 1, 0, r_op(ALU_ADD, 3, 1, 2, t++),   1, 0, K_RESET,  0);
    add(0, 1, 0, r_op(ALU_ADD, 3, 1, 2, t++),   1, 0, K_LOAD,   0);  // ADD r3,r1,r2
    add(0, 1, 0, r_op(ALU_SUB, 4, 5, 6, t++),   1, 0, K_LOAD,   0);  // SUB r4,r5,r6
    add(0, 1, 0, lw(2, 1, t++),                 1, 0, K_LOAD,   0);  // LW r2,0(r1)
    add(0, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 1, K_BUBBLE, 1);  // use of r2 -> stall
    add(0, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_LOAD,   1);  // re-presented
    add(0, 1, 0, lw(0, 1, t++),                 1, 0, K_LOAD,   1);  // LW r0
    add(0, 1, 0, r_op(ALU_ADD, 3, 0, 0, t++),   1, 0, K_LOAD,   1);  // r0 never hazards
    add(0, 1, 0, lw(2, 1, t++),                 1, 0, K_LOAD,   1);
    add(0, 1, 1, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_BUBBLE, 1);  // flush beats hazard
    add(0, 1, 0, lw(2, 1, t++),                 1, 0, K_LOAD,   1);
    add(0, 0, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_HOLD,   1);  // frozen x3
    add(0, 0, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_HOLD,   1);
    add(0, 0, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_HOLD,   1);
    add(0, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 1, K_BUBBLE, 2);  // single stall after thaw
    add(0, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_LOAD,   2);
    add(0, 1, 0, lw(5, 3, t++),                 1, 0, K_LOAD,   2);
    add(0, 1, 0, lw(6, 5, t++),                 1, 1, K_BUBBLE, 3);  // back-to-back loads
    add(0, 1, 0, lw(6, 5, t++),                 1, 0, K_LOAD,   3);
    add(0, 1, 0, r_op(ALU_ADD, 7, 6, 6, t++),   1, 1, K_BUBBLE, 4);
    add(0, 1, 0, r_op(ALU_ADD, 7, 6, 6, t++),   1, 0, K_LOAD,   4);
    add(0, 1, 0, lw(8, 1, t++),                 1, 0, K_LOAD,   4);
    add(0, 1, 0, r_op(ALU_SUB, 9, 1, 8, t++),   1, 1, K_BUBBLE, 5);  // match on rt only
    add(0, 1, 0, r_op(ALU_SUB, 9, 1, 8, t++),   1, 0, K_LOAD,   5);
    add(0, 1, 0, lw(2, 1, t++),                 1, 0, K_LOAD,   5);
    add(1, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   0, 0, K_RESET,  0);  // reset mid-stall
    add(0, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_LOAD,   0);
    add(0, 1, 0, lw(2, 1, t++),                 1, 0, K_LOAD,   0);
    add(1, 0, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_RESET,  0);  // reset beats freeze
    add(0, 1, 0, lw(2, 1, t++),                 1, 0, K_LOAD,   0);
    add(0, 1, 1, r_op(ALU_SUB, 4, 5, 6, t++),   1, 0, K_BUBBLE, 0);  // plain flush
    add(0, 1, 0, r_op(ALU_ADD, 3, 2, 4, t++),   1, 0, K_LOAD,   0);
    add(0, 0, 1, lw(2, 1, t++),                 1, 0, K_HOLD,   0);  // freeze beats flush

    prev = '0;
    rst  = 1'b1;
    en   = 1'b1;
    fl   = 1'b0;
    in_b = '0;

    foreach (tbl[i]) begin
      v    = tbl[i];
      rst  = v.rst;
      en   = v.en;
      fl   = v.fl;
      in_b = v.in;

      case (v.kind)
        K_LOAD:   e.b = v.in;
        K_BUBBLE: begin
          e.b     = v.in;
          e.b.exe = BUBBLE_EXE_CTRL;
          e.b.mem = BUBBLE_MEM_CTRL;
          e.b.wrb = BUBBLE_WRB_CTRL;
        end
        K_HOLD:   e.b = prev.b;
        default:  e.b = '0;
      endcase
`ifdef ID_EX_STALL_CNT_EN
      e.cnt = 32'(v.exp_cnt);
`else
      e.cnt = 32'd0;
`endif
      sb.push_back(e);
      prev = e;

      @(negedge clk);
      if (v.chk_stall) begin
        n_tests++;
        if (o_stall !== v.exp_stall) begin
          n_fail++;
          $display("FAIL stall row %0d: got %b, expected %b", i, o_stall, v.exp_stall);
        end
      end

      @(posedge clk);
      #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard row %0d: got empty queue, expected one entry", i);
      end else begin
        e         = sb.pop_front();
        got.b.exe = o_exe;
        got.b.mem = o_mem;
        got.b.wrb = o_wrb;
        got.b.rs_data = o_rs_data;
        got.b.rt_data = o_rt_data;
        got.b.imm     = o_imm;
        got.b.pc      = o_pc;
        got.b.rs_addr = o_rs_addr;
        got.b.rt_addr = o_rt_addr;
        got.b.rd_addr = o_rd_addr;
        got.cnt       = o_cnt;
        if (got.b !== e.b) begin
          n_fail++;
          $display("FAIL ex_regs row %0d: got %h, expected %h", i, got.b, e.b);
        end
        n_tests++;
        if (got.cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL stall_count row %0d: got %0d, expected %0d", i, got.cnt, e.cnt);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
